// File: rtl/divmmc_pager.sv
// divmmc_pager: DivMMC overlay paging controller for the ZX48 memory map.
//
// Watches Z80 opcode fetches and I/O writes, runs the automap state machine,
// holds the 0xE3 control register and sequences the NMI button.
//
// Every CPU input is first captured in a sampling register. All events are
// derived from those samples, and the state and outputs update one clock
// later. As a result, a condition that is present at rising edge k shows on
// the outputs after rising edge k+1.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset
//   enable  in   DivMMC enable; 0 forces automap, NMI request and divMap low
//   mreq    in   CPU MREQ (active low)
//   iorq    in   CPU IORQ (active low)
//   m1      in   CPU M1   (active low)
//   wr      in   CPU WR   (active low)
//   a       in   CPU address bus [15:0]
//   d       in   CPU data out [7:0]
//   nmiBtn  in   NMI button, active high, already synchronised
//   divMap  out  overlay active
//   divRam  out  0x0000-0x1FFF served by RAM page 3 instead of esxDOS ROM
//   divPage out  bank shown at 0x2000-0x3FFF
//   nmi     out  NMI to the CPU (active low)
module divmmc_pager #(
  parameter logic [7:0] PORT = 8'hE3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        m1,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        nmiBtn,
  output logic        divMap,
  output logic        divRam,
  output logic [3:0]  divPage,
  output logic        nmi
);

  typedef enum logic {IDLE = 1'b0, MAPPED = 1'b1} state_e;

  // Input samples and edge-detect history
  logic        enable_q, mreq_q, iorq_q, m1_q, wr_q, nmi_btn_q;
  logic [15:0] a_q;
  logic [7:0]  d_q;
  logic        fetch_prev_q, m1_prev_q, pw_prev_q, nmi_btn_prev_q;

  // Architectural state
  state_e      state_q, state_d;
  logic        pend_on_q, pend_on_d;
  logic        pend_off_q, pend_off_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        conmem_q, conmem_d;
  logic        mapram_q, mapram_d;
  logic [3:0]  page_q, page_d;

  // Registered outputs
  logic        div_map_q, div_map_d;
  logic        div_ram_q, div_ram_d;
  logic        nmi_q, nmi_d;

  // Events, all derived from sampled values
  logic fetch, fetch_start, fetch_end, pw, pw_start, btn_rise;
  logic trap_instant, trap_delayed, trap_nmi, trap_off;

  assign fetch        = !m1_q && !mreq_q;
  assign fetch_start  = fetch && !fetch_prev_q;
  assign fetch_end    = m1_q && !m1_prev_q;
  assign pw           = !iorq_q && !wr_q && (a_q[7:0] == PORT);
  assign pw_start     = pw && !pw_prev_q;
  assign btn_rise     = nmi_btn_q && !nmi_btn_prev_q;

  assign trap_instant = (a_q[15:8] == 8'h3D);
  assign trap_delayed = (a_q == 16'h0000) || (a_q == 16'h0008) || (a_q == 16'h0038) ||
                        (a_q == 16'h04C6) || (a_q == 16'h0562);
  assign trap_nmi     = (a_q == 16'h0066);
  assign trap_off     = (a_q[15:3] == 13'h03FF);  // 0x1FF8-0x1FFF

  // NOTE: the sampling and history registers are plain pipeline stages and
  // are not reset. They track the bus on every clock, including during reset.
  // So a fetch that is still in progress when reset is released does not
  // produce a second fetchStart.
  always_ff @(posedge clock) begin
    enable_q       <= enable;
    mreq_q         <= mreq;
    iorq_q         <= iorq;
    m1_q           <= m1;
    wr_q           <= wr;
    a_q            <= a;
    d_q            <= d;
    nmi_btn_q      <= nmiBtn;
    fetch_prev_q   <= fetch;
    m1_prev_q      <= m1_q;
    pw_prev_q      <= pw;
    nmi_btn_prev_q <= nmi_btn_q;
  end

  // NOTE: every signal is given a default first, so no path through the block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pend_on_d  = pend_on_q;
    pend_off_d = pend_off_q;
    nmi_pend_d = nmi_pend_q;
    conmem_d   = conmem_q;
    mapram_d   = mapram_q;
    page_d     = page_q;

    if (pw_start) begin
      conmem_d = d_q[7];
      mapram_d = mapram_q | d_q[6];  // write-once until reset
      page_d   = d_q[3:0];
    end

    if (btn_rise && state_q == IDLE && !nmi_pend_q) nmi_pend_d = 1'b1;

    if (fetch_start) begin
      if (trap_instant) begin
        state_d    = MAPPED;
        pend_off_d = 1'b0;
      end
      if (trap_delayed) pend_on_d = 1'b1;
      if (trap_nmi && nmi_pend_q) begin
        pend_on_d  = 1'b1;
        nmi_pend_d = 1'b0;
      end
      if (trap_off && state_q == MAPPED) pend_off_d = 1'b1;
    end

    // fetchStart needs M1 low and fetchEnd needs M1 high, so the two never
    // coincide. That makes the registered pending flags the right ones here.
    if (fetch_end) begin
      if (pend_on_q)       state_d = MAPPED;
      else if (pend_off_q) state_d = IDLE;
      pend_on_d  = 1'b0;
      pend_off_d = 1'b0;
    end

    if (!enable_q) begin
      state_d    = IDLE;
      pend_on_d  = 1'b0;
      pend_off_d = 1'b0;
      nmi_pend_d = 1'b0;
    end

    // The outputs are built from next-state values, so a port write and a
    // fetchEnd in the same clock land together.
    div_map_d = enable_q && (conmem_d || (state_d == MAPPED));
    div_ram_d = mapram_d && !conmem_d;
    nmi_d     = !nmi_pend_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_on_q  <= 1'b0;
      pend_off_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      conmem_q   <= 1'b0;
      mapram_q   <= 1'b0;
      page_q     <= 4'h0;
      div_map_q  <= 1'b0;
      div_ram_q  <= 1'b0;
      nmi_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      nmi_pend_q <= nmi_pend_d;
      conmem_q   <= conmem_d;
      mapram_q   <= mapram_d;
      page_q     <= page_d;
      div_map_q  <= div_map_d;
      div_ram_q  <= div_ram_d;
      nmi_q      <= nmi_d;
    end
  end

  assign divMap  = div_map_q;
  assign divRam  = div_ram_q;
  assign divPage = page_q;
  assign nmi     = nmi_q;

endmodule

// File: doc/divmmc_pager.md
# divmmc_pager

Paging controller for the DivMMC overlay in the ZX48 memory map. It watches CPU opcode fetches and I/O writes, runs the automap state machine, and holds the 0xE3 control register. It also sequences the NMI button. It drives `divMap`, `divRam` and `divPage` into the memory block, which selects esxDOS ROM, DivMMC RAM page 3, or the banked 8K window at 0x2000–0x3FFF.

## Interface
Parameters:
- `PORT`, 8'hE3, low address byte of the control register port.

Ports:
- `clock`  in  1  system clock; every input is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  DivMMC enable; while 0, automap, the NMI request and `divMap` are held at 0.
- `mreq`  in  1  CPU MREQ, active low.
- `iorq`  in  1  CPU IORQ, active low.
- `m1`  in  1  CPU M1, active low.
- `wr`  in  1  CPU WR, active low.
- `a`  in  16  CPU address bus.
- `d`  in  8  CPU data out.
- `nmiBtn`  in  1  NMI button, active high, already synchronised.
- `divMap`  out  1  overlay active.
- `divRam`  out  1  0x0000–0x1FFF is served by RAM page 3 instead of the esxDOS ROM.
- `divPage`  out  4  bank shown at 0x2000–0x3FFF.
- `nmi`  out  1  NMI to the CPU, active low.

## Operation
- Fetch detection:
  - `fetch = !m1 && !mreq`. Both terms are registered, so every term below depends only on values sampled at clock edges.
  - `fetchStart` is the first clock on which `fetch` is true.
  - `fetchEnd` is the first clock on which `m1` is high after having been low.
- Control register (port write):
  - A port write is `!iorq && !wr && a[7:0]==PORT`. It acts once, on its first active clock.
  - `conmem`←d[7] and `divPage`←d[3:0].
  - `mapram`←`mapram|d[6]`. MAPRAM is write-once and is cleared only by `reset`.
- Automap state machine, states IDLE / MAPPED:
  - `automap` is the state bit; `pendOn` and `pendOff` are the pending flags.
  - At `fetchStart` with a in 0x3D00–0x3DFF: instant map. Set `automap` immediately and clear `pendOff`.
  - At `fetchStart` with a ∈ {0x0000, 0x0008, 0x0038, 0x04C6, 0x0562}: set `pendOn`.
  - At `fetchStart` with a = 0x0066: set `pendOn` only if `nmiPend` is set.
  - At `fetchStart` with a in 0x1FF8–0x1FFF: set `pendOff`. This applies only in MAPPED.
  - At `fetchEnd`: `pendOn` → MAPPED, and `pendOff` → IDLE. If both are set, `pendOn` wins. Both flags then clear.
  - Non-M1 memory accesses never change state.
- NMI:
  - A rising edge of `nmiBtn` sets `nmiPend`, provided `automap`=0 and `enable`=1.
  - `nmi` = !`nmiPend`.
  - `nmiPend` clears at the `fetchStart` of the fetch at 0x0066.
  - Further button edges are ignored while `nmiPend` is set or while in MAPPED.
- Outputs (all registered):
  - `divMap` = enable & (conmem | automap).
  - `divRam` = mapram & !conmem.
  - `divPage` is the register value.

## Timing
- Reset values: `divMap`=0, `divRam`=0, `divPage`=0, `nmi`=1. All internal flags and state also reset to 0 / IDLE.
- Reset mid-fetch: any pending transition is discarded.
- Instant map: `divMap` goes high 1 clock after the `fetchStart` clock. This is before the opcode data is read, because the CPU read completes ≥2 clocks later.
- Delayed map/unmap: `divMap` changes 1 clock after the `fetchEnd` clock, so the triggering opcode is fetched from the previous mapping.
- Port write: register outputs update 1 clock after the first active clock. A write held for N clocks has the same effect as a single clock.
- `nmi` falls 1 clock after the `nmiBtn` edge. It rises 1 clock after the 0x0066 `fetchStart`.
- `enable` falling: `divMap` goes low next clock. `automap` and the pending flags clear and `nmi` rises; the register values are kept.
- Simultaneous events in one clock:
  - A port write and a `fetchEnd` both take effect.
  - `divMap` uses the new `conmem` together with the new `automap`.

## Test plan
- Reset then fetch 0x0000 → `divMap` stays 0 during the fetch and goes 1 one clock after `fetchEnd`. A following fetch at 0x1FF8 → `divMap` returns to 0 after that fetch's `fetchEnd`.
- Fetch at 0x3D2F from IDLE → `divMap`=1 one clock after `fetchStart`, before `fetchEnd`.
- OUT 0xE3,0xC5 → `conmem`=1, `mapram`=1, `divPage`=5, `divRam`=0, `divMap`=1. Then OUT 0xE3,0x03 → `divPage`=3, `divRam`=1, and `divMap` follows `automap` (0 in IDLE).
- With `mapram` set, OUT 0xE3,0x00 → `divRam` stays 1. `reset` → `divRam`=0.
- `nmiBtn` pulse → `nmi`=0. Fetch at 0x0066 → `nmi`=1, and `divMap`=1 after `fetchEnd`. A fetch at 0x0066 without a prior button pulse → no map.
- `enable`=0 while MAPPED → `divMap`=0 next clock. After `enable`=1, `divMap` stays 0 until the next trap fetch.
